// File: rtl/interrupt_controller_if.sv
// Request, handshake and configuration signals between the CPU side (master)
// and the interrupt controller (slave).
interface interrupt_controller_if #(
    parameter int NUM_SRC = 4
);
    localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ADDR_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0] irq_src;
    logic               ACK;
    logic               int_done;
    logic               cfg_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [31:0]        cfg_wdata;
    logic               INT;
    logic [31:0]        INT_INSTR;
    logic [ID_W-1:0]    active_id;
    logic               busy;

    modport master (
        output irq_src, ACK, int_done, cfg_we, cfg_addr, cfg_wdata,
        input  INT, INT_INSTR, active_id, busy
    );

    modport slave (
        input  irq_src, ACK, int_done, cfg_we, cfg_addr, cfg_wdata,
        output INT, INT_INSTR, active_id, busy
    );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches request edges, raises INT, and on ACK
// injects NOOP padding followed by a jump to the selected handler vector.
module interrupt_controller #(
    parameter int          NUM_SRC     = 4,
    parameter int          INJ_PAD     = 2,
    parameter logic [31:0] DEFAULT_VEC = 32'h0600_2000,
    parameter logic [31:0] INSTR_NOOP  = 32'h7800_0000
) (
    input logic                   clk,
    input logic                   rst,
    interrupt_controller_if.slave bus
);
    localparam int         ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int         ADDR_W   = $clog2(NUM_SRC + 1);
    localparam logic [2:0] PAD_LAST = 3'(INJ_PAD);

    typedef enum logic [1:0] {IDLE, REQUEST, INJECT, SERVICE} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] int_en_q, int_en_d;
    logic [31:0]        vector_q [NUM_SRC];
    logic [31:0]        vector_d [NUM_SRC];
    logic [28:2]        jump_vec_q, jump_vec_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [2:0]         inj_cnt_q, inj_cnt_d;
    logic               int_q, int_d;
    logic [31:0]        instr_q, instr_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_mask;
    logic [ID_W-1:0]    sel_id;
    logic               ack_take;

    // Lowest eligible index wins; the loop runs downward so the last hit is the winner.
    always_comb begin
        eligible = pending_q & int_en_q;
        sel_id   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = ID_W'(i);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        vector_d = vector_q;
        int_en_d = int_en_q;
        if (bus.cfg_we) begin
            if (bus.cfg_addr == ADDR_W'(NUM_SRC)) int_en_d = bus.cfg_wdata[NUM_SRC-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.cfg_addr == ADDR_W'(i)) vector_d[i] = bus.cfg_wdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        jump_vec_d  = jump_vec_q;
        inj_cnt_d   = inj_cnt_q;
        ack_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    active_id_d = sel_id;
                    jump_vec_d  = vector_q[sel_id][28:2];
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                if (bus.ACK) begin
                    ack_take  = 1'b1;
                    inj_cnt_d = 3'd0;
                    state_d   = INJECT;
                end
            end
            INJECT: begin
                if (inj_cnt_q == PAD_LAST) state_d = SERVICE;
                else                       inj_cnt_d = inj_cnt_q + 3'd1;
            end
            SERVICE: begin
                if (bus.int_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge in the acknowledge cycle outranks the clear of the active source.
        clr_mask = '0;
        if (ack_take) clr_mask[active_id_q] = 1'b1;
        irq_prev_d = bus.irq_src;
        pending_d  = (pending_q & ~clr_mask) | (bus.irq_src & ~irq_prev_q);

        int_d   = (state_q == REQUEST);
        instr_d = ((state_q == INJECT) && (inj_cnt_q == PAD_LAST))
                  ? {5'b10100, jump_vec_q} : INSTR_NOOP;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            irq_prev_q  <= '0;
            pending_q   <= '0;
            int_en_q    <= '1;
            jump_vec_q  <= '0;
            active_id_q <= '0;
            inj_cnt_q   <= '0;
            int_q       <= 1'b0;
            instr_q     <= INSTR_NOOP;
            // NOTE: the vector table is reset because its defaults are architectural, not scratch data.
            for (int i = 0; i < NUM_SRC; i++) begin
                vector_q[i] <= DEFAULT_VEC + 32'(i) * 32'h100;
            end
        end else begin
            state_q     <= state_d;
            irq_prev_q  <= irq_prev_d;
            pending_q   <= pending_d;
            int_en_q    <= int_en_d;
            jump_vec_q  <= jump_vec_d;
            active_id_q <= active_id_d;
            inj_cnt_q   <= inj_cnt_d;
            int_q       <= int_d;
            instr_q     <= instr_d;
            vector_q    <= vector_d;
        end
    end

    assign bus.INT       = int_q;
    assign bus.INT_INSTR = instr_q;
    assign bus.active_id = active_id_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed handshake scenarios, then randomized
// traffic checked against a transaction-level model of pending/enable/vectors.
module tb_interrupt_controller;
    localparam int          NUM_SRC = 4;
    localparam int          INJ_PAD = 2;
    localparam logic [31:0] NOOP    = 32'h7800_0000;
    localparam logic [31:0] DEF_VEC = 32'h0600_2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

    interrupt_controller #(
        .NUM_SRC(NUM_SRC), .INJ_PAD(INJ_PAD), .DEFAULT_VEC(DEF_VEC), .INSTR_NOOP(NOOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]        m_vec [NUM_SRC];
    logic [NUM_SRC-1:0] m_en;
    logic [NUM_SRC-1:0] m_pend;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] jump_of(input logic [31:0] v);
        return {5'b10100, v[28:2]};
    endfunction

    function automatic int lowest(input logic [NUM_SRC-1:0] m);
        for (int i = 0; i < NUM_SRC; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_en   = '1;
        m_pend = '0;
        for (int i = 0; i < NUM_SRC; i++) m_vec[i] = DEF_VEC + 32'(i) * 32'h100;
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] mask);
        bus.irq_src = mask;
        tick();
        m_pend |= mask;
        bus.irq_src = '0;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(addr);
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
        if (addr == NUM_SRC) m_en = data[NUM_SRC-1:0];
        else if (addr < NUM_SRC) m_vec[addr] = data;
    endtask

    // Cause edge already taken: REQUEST after one more edge, INT visible after two.
    task automatic expect_rise(input string tag);
        tick();
        check({tag, ".int_pre"}, 32'(bus.INT), 32'd0);
        check({tag, ".busy_pre"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, ".int_rise"}, 32'(bus.INT), 32'd1);
    endtask

    task automatic service(input string tag, input int exp_id, input logic [31:0] exp_vec,
                           input bit reirq, input int ack_delay);
        logic [NUM_SRC-1:0] one;
        one = '0;
        one[exp_id] = 1'b1;
        check({tag, ".int"}, 32'(bus.INT), 32'd1);
        check({tag, ".id"}, 32'(bus.active_id), 32'(exp_id));
        for (int d = 0; d < ack_delay; d++) begin
            tick();
            check({tag, ".int_hold"}, 32'(bus.INT), 32'd1);
        end
        bus.ACK     = 1'b1;
        bus.irq_src = reirq ? one : '0;
        tick();
        bus.ACK     = 1'b0;
        bus.irq_src = '0;
        m_pend[exp_id] = reirq;
        for (int j = 0; j <= INJ_PAD; j++) begin
            tick();
            check({tag, ".int_low"}, 32'(bus.INT), 32'd0);
            check({tag, ".instr"}, bus.INT_INSTR, (j == INJ_PAD) ? jump_of(exp_vec) : NOOP);
        end
        tick();
        check({tag, ".instr_post"}, bus.INT_INSTR, NOOP);
        check({tag, ".busy_svc"}, 32'(bus.busy), 32'd1);
        check({tag, ".id_svc"}, 32'(bus.active_id), 32'(exp_id));
    endtask

    task automatic done(input string tag);
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int id;
        bus.irq_src   = '0;
        bus.ACK       = 1'b0;
        bus.int_done  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        check("rst.int", 32'(bus.INT), 32'd0);
        check("rst.instr", bus.INT_INSTR, NOOP);
        check("rst.id", 32'(bus.active_id), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single request on source 2.
        pulse(4'b0100);
        expect_rise("single");
        service("single", 2, 32'h0600_2200, 1'b0, 0);
        done("single");

        // Same-cycle edges on sources 3 and 1.
        pulse(4'b1010);
        expect_rise("prio1");
        service("prio1", 1, 32'h0600_2100, 1'b0, 1);
        done("prio1");
        expect_rise("prio3");
        service("prio3", 3, 32'h0600_2300, 1'b0, 0);
        done("prio3");

        // Masked source still latches, then fires once enabled.
        cfg_write(NUM_SRC, 32'hE);
        pulse(4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mask.int", 32'(bus.INT), 32'd0);
        end
        cfg_write(NUM_SRC, 32'hF);
        expect_rise("unmask");
        service("unmask", 0, 32'h0600_2000, 1'b0, 0);
        done("unmask");

        // Vector rewritten after selection only affects the next interrupt.
        pulse(4'b0010);
        expect_rise("vec_old");
        cfg_write(1, 32'h0600_3000);
        service("vec_old", 1, 32'h0600_2100, 1'b0, 0);
        done("vec_old");
        pulse(4'b0010);
        expect_rise("vec_new");
        service("vec_new", 1, 32'h0600_3000, 1'b0, 0);
        done("vec_new");

        // New edge on the active source during the ACK cycle.
        pulse(4'b0100);
        expect_rise("clr_race");
        service("clr_race", 2, 32'h0600_2200, 1'b1, 0);
        done("clr_race");
        expect_rise("clr_again");
        service("clr_again", 2, 32'h0600_2200, 1'b0, 0);
        done("clr_again");

        // Stray handshakes, then reset in the middle of INJECT.
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        check("stray_ack.busy", 32'(bus.busy), 32'd0);
        tick();
        check("stray_ack.int", 32'(bus.INT), 32'd0);
        pulse(4'b1001);
        expect_rise("stray_done");
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
        check("stray_done.int", 32'(bus.INT), 32'd1);
        check("stray_done.busy", 32'(bus.busy), 32'd1);
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        tick();
        check("inject.int", 32'(bus.INT), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mid_rst.int", 32'(bus.INT), 32'd0);
        check("mid_rst.instr", bus.INT_INSTR, NOOP);
        check("mid_rst.busy", 32'(bus.busy), 32'd0);
        check("mid_rst.id", 32'(bus.active_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst.lost", 32'(bus.INT), 32'd0);
        end

        // Randomized traffic, serviced by a bench-side CPU.
        pulse(4'b0001 << $urandom_range(0, NUM_SRC - 1));
        expect_rise("rnd.first");
        id = lowest(m_pend & m_en);
        service("rnd.first", id, m_vec[id], 1'b0, 0);
        for (int it = 0; it < 40; it++) begin
            int nact;
            nact = $urandom_range(0, 3);
            for (int a = 0; a < nact; a++) begin
                case ($urandom_range(0, 2))
                    0:       pulse(NUM_SRC'($urandom_range(0, 15)));
                    1:       cfg_write($urandom_range(0, 7), $urandom);
                    default: cfg_write(NUM_SRC, 32'($urandom_range(0, 15)));
                endcase
            end
            done("rnd");
            if ((m_pend & m_en) == '0) begin
                tick();
                check("rnd.idle", 32'(bus.INT), 32'd0);
                cfg_write(NUM_SRC, 32'hF);
                if (m_pend == '0) pulse(4'b0001 << $urandom_range(0, NUM_SRC - 1));
            end
            expect_rise("rnd");
            id = lowest(m_pend & m_en);
            service("rnd", id, m_vec[id], 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        done("rnd.last");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
